// File: rtl/ahbl_pkg.sv
// AHB-lite shared encodings for the bus fabric.
// Transfer types and response codes.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_addr_decode.sv
// Priority address decoder for the AHB-lite splitter.
// Lowest hitting connected port wins; no hit flags a miss.
module ahbl_addr_decode #(
  parameter int                          N_PORTS   = 2,
  parameter int                          W_ADDR    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = '0,
  parameter logic [N_PORTS-1:0]          CONN_MASK = '1
) (
  input  logic [W_ADDR-1:0]  addr,
  output logic [N_PORTS-1:0] sel,
  output logic               miss
);

  logic [N_PORTS-1:0] hit;
  logic               found;

  // Raw per-port match, disconnected ports never hit
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      hit[i] = ((addr & ADDR_MASK[i*W_ADDR +: W_ADDR])
               == ADDR_MAP[i*W_ADDR +: W_ADDR])
               & CONN_MASK[i];
    end
  end

  // Keep only the lowest-index hit
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (hit[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    miss = ~found;
  end

endmodule

// File: rtl/onehot_mux.sv
// One-hot selected OR-mux.
// An all-zero select yields zero.
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  // OR together every selected lane
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) dout = dout | din[i*W +: W];
    end
  end

endmodule

// File: rtl/ahbl_splitter_burst.sv
// AHB-lite 1:N splitter with burst-held decode.
// Unmapped transfers get a two-cycle ERROR and bump a debug counter.
module ahbl_splitter_burst
  import ahbl_pkg::*;
#(
  parameter int                        N_PORTS   = 2,
  parameter int                        W_ADDR    = 32,
  parameter int                        W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0,
  parameter logic [N_PORTS-1:0]        CONN_MASK = '1,
  parameter int                        W_ERRCNT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     src_hready,
  output logic                     src_hready_resp,
  output logic                     src_hresp,
  input  logic [W_ADDR-1:0]        src_haddr,
  input  logic                     src_hwrite,
  input  logic [1:0]               src_htrans,
  input  logic [2:0]               src_hsize,
  input  logic [2:0]               src_hburst,
  input  logic [3:0]               src_hprot,
  input  logic                     src_hmastlock,
  input  logic [W_DATA-1:0]        src_hwdata,
  output logic [W_DATA-1:0]        src_hrdata,
  input  logic                     src_hexcl,
  input  logic [7:0]               src_hmaster,
  output logic                     src_hexokay,
  output logic [N_PORTS-1:0]       dst_hready,
  input  logic [N_PORTS-1:0]       dst_hready_resp,
  input  logic [N_PORTS-1:0]       dst_hresp,
  output logic [N_PORTS*W_ADDR-1:0] dst_haddr,
  output logic [N_PORTS-1:0]       dst_hwrite,
  output logic [2*N_PORTS-1:0]     dst_htrans,
  output logic [3*N_PORTS-1:0]     dst_hsize,
  output logic [3*N_PORTS-1:0]     dst_hburst,
  output logic [4*N_PORTS-1:0]     dst_hprot,
  output logic [N_PORTS-1:0]       dst_hmastlock,
  output logic [N_PORTS*W_DATA-1:0] dst_hwdata,
  input  logic [N_PORTS*W_DATA-1:0] dst_hrdata,
  output logic [N_PORTS-1:0]       dst_hexcl,
  output logic [8*N_PORTS-1:0]     dst_hmaster,
  input  logic [N_PORTS-1:0]       dst_hexokay,
  output logic [W_ERRCNT-1:0]      err_count,
  input  logic                     err_count_clr
);

  logic [N_PORTS-1:0] dec_sel;
  logic               dec_miss;
  logic [N_PORTS-1:0] sel_a;
  logic               miss_a;
  logic [N_PORTS-1:0] burst_sel;
  logic               burst_miss;
  logic [N_PORTS-1:0] sel_d;
  logic               err_d;
  logic               err_ph1;
  logic               new_err;

  ahbl_addr_decode #(
    .N_PORTS   (N_PORTS),
    .W_ADDR    (W_ADDR),
    .ADDR_MAP  (ADDR_MAP),
    .ADDR_MASK (ADDR_MASK),
    .CONN_MASK (CONN_MASK)
  ) u_dec (
    .addr (src_haddr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  // Fresh decode on NONSEQ, held decode for the rest of a burst
  always_comb begin
    sel_a  = '0;
    miss_a = 1'b0;
    case (src_htrans)
      HTRANS_NONSEQ: begin
        sel_a  = dec_sel;
        miss_a = dec_miss;
      end
      HTRANS_SEQ, HTRANS_BUSY: begin
        sel_a  = burst_sel;
        miss_a = burst_miss;
      end
      default: ;
    endcase
  end

  // BUSY never errors, only real transfers do
  assign new_err = miss_a & src_htrans[1];

  // Broadcast everything except htrans, which is gated per port
  assign dst_hready    = {N_PORTS{src_hready}};
  assign dst_haddr     = {N_PORTS{src_haddr}};
  assign dst_hwrite    = {N_PORTS{src_hwrite}};
  assign dst_hsize     = {N_PORTS{src_hsize}};
  assign dst_hburst    = {N_PORTS{src_hburst}};
  assign dst_hprot     = {N_PORTS{src_hprot}};
  assign dst_hmastlock = {N_PORTS{src_hmastlock}};
  assign dst_hwdata    = {N_PORTS{src_hwdata}};
  assign dst_hexcl     = {N_PORTS{src_hexcl}};
  assign dst_hmaster   = {N_PORTS{src_hmaster}};

  for (genvar i = 0; i < N_PORTS; i++) begin : g_trans
    assign dst_htrans[2*i +: 2] = sel_a[i] ? src_htrans : HTRANS_IDLE;
  end

  // Remember the burst-start decode; IDLE drops it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_sel  <= '0;
      burst_miss <= 1'b0;
    end else if (src_hready) begin
      if (src_htrans == HTRANS_NONSEQ) begin
        burst_sel  <= dec_sel;
        burst_miss <= dec_miss;
      end else if (src_htrans == HTRANS_IDLE) begin
        burst_sel  <= '0;
        burst_miss <= 1'b0;
      end
    end
  end

  // Data-phase state; err_ph1 marks the stalled first ERROR cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_d   <= '0;
      err_d   <= 1'b0;
      err_ph1 <= 1'b0;
    end else if (src_hready) begin
      sel_d   <= sel_a;
      err_d   <= new_err;
      err_ph1 <= new_err;
    end else begin
      err_ph1 <= 1'b0;
    end
  end

  // Responses come from registered data-phase state only
  always_comb begin
    src_hready_resp = 1'b1;
    src_hresp       = HRESP_OKAY;
    src_hexokay     = 1'b0;
    if (err_d) begin
      src_hready_resp = ~err_ph1;
      src_hresp       = HRESP_ERROR;
    end else if (|sel_d) begin
      src_hready_resp = |(dst_hready_resp & sel_d);
      src_hresp       = |(dst_hresp & sel_d);
      src_hexokay     = |(dst_hexokay & sel_d);
    end
  end

  onehot_mux #(
    .N (N_PORTS),
    .W (W_DATA)
  ) u_rdata_mux (
    .sel  (sel_d),
    .din  (dst_hrdata),
    .dout (src_hrdata)
  );

  // Saturating decode-error counter; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= '0;
    end else if (err_d && err_ph1 && !(&err_count)) begin
      err_count <= err_count + {{(W_ERRCNT-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// Directed bench for the AHB-lite burst splitter.
// Instance a: overlapping maps; instance b: port 0 disconnected.
module tb_ahbl_splitter_burst;
  import ahbl_pkg::*;

  localparam int N = 2;
  localparam int WA = 32;
  localparam int WD = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [WA-1:0] haddr = '0;
  logic          hwrite = 1'b0;
  logic [1:0]    htrans = HTRANS_IDLE;
  logic [2:0]    hsize = 3'd2;
  logic [2:0]    hburst = 3'd0;
  logic [3:0]    hprot = 4'h3;
  logic          hmastlock = 1'b0;
  logic [WD-1:0] hwdata = '0;
  logic          hexcl = 1'b0;
  logic [7:0]    hmaster = 8'h01;
  logic          clr = 1'b0;

  logic [N-1:0]    s_rdy = 2'b11;
  logic [N-1:0]    s_resp = 2'b00;
  logic [N*WD-1:0] s_rdata = '0;
  logic [N-1:0]    s_exok = 2'b00;
  logic [N-1:0]    b_srdy = 2'b11;
  logic [N-1:0]    b_zero = 2'b00;
  logic [N*WD-1:0] b_zrd = '0;

  logic            a_rdy, a_resp, a_exok;
  logic [WD-1:0]   a_rdata;
  logic [N-1:0]    a_dhr, a_dwr, a_dml, a_dex;
  logic [N*WA-1:0] a_dad;
  logic [2*N-1:0]  a_dtr;
  logic [3*N-1:0]  a_dsz, a_dbu;
  logic [4*N-1:0]  a_dpr;
  logic [N*WD-1:0] a_dwd;
  logic [8*N-1:0]  a_dms;
  logic [7:0]      a_cnt;

  logic            b_rdy, b_resp, b_exok;
  logic [WD-1:0]   b_rdata;
  logic [N-1:0]    b_dhr, b_dwr, b_dml, b_dex;
  logic [N*WA-1:0] b_dad;
  logic [2*N-1:0]  b_dtr;
  logic [3*N-1:0]  b_dsz, b_dbu;
  logic [4*N-1:0]  b_dpr;
  logic [N*WD-1:0] b_dwd;
  logic [8*N-1:0]  b_dms;
  logic [7:0]      b_cnt;

  ahbl_splitter_burst #(
    .N_PORTS   (N),
    .W_ADDR    (WA),
    .W_DATA    (WD),
    .ADDR_MAP  ({32'h0000_0000, 32'h2000_0000}),
    .ADDR_MASK ({32'h8000_0000, 32'hF000_0000}),
    .CONN_MASK (2'b11),
    .W_ERRCNT  (8)
  ) u_a (
    .clk (clk), .rst_n (rst_n),
    .src_hready (a_rdy), .src_hready_resp (a_rdy),
    .src_hresp (a_resp), .src_haddr (haddr),
    .src_hwrite (hwrite), .src_htrans (htrans),
    .src_hsize (hsize), .src_hburst (hburst),
    .src_hprot (hprot), .src_hmastlock (hmastlock),
    .src_hwdata (hwdata), .src_hrdata (a_rdata),
    .src_hexcl (hexcl), .src_hmaster (hmaster),
    .src_hexokay (a_exok), .dst_hready (a_dhr),
    .dst_hready_resp (s_rdy), .dst_hresp (s_resp),
    .dst_haddr (a_dad), .dst_hwrite (a_dwr),
    .dst_htrans (a_dtr), .dst_hsize (a_dsz),
    .dst_hburst (a_dbu), .dst_hprot (a_dpr),
    .dst_hmastlock (a_dml), .dst_hwdata (a_dwd),
    .dst_hrdata (s_rdata), .dst_hexcl (a_dex),
    .dst_hmaster (a_dms), .dst_hexokay (s_exok),
    .err_count (a_cnt), .err_count_clr (clr)
  );

  ahbl_splitter_burst #(
    .N_PORTS   (N),
    .W_ADDR    (WA),
    .W_DATA    (WD),
    .ADDR_MAP  ({32'h4000_0000, 32'h2000_0000}),
    .ADDR_MASK ({32'hF000_0000, 32'hF000_0000}),
    .CONN_MASK (2'b10),
    .W_ERRCNT  (8)
  ) u_b (
    .clk (clk), .rst_n (rst_n),
    .src_hready (b_rdy), .src_hready_resp (b_rdy),
    .src_hresp (b_resp), .src_haddr (haddr),
    .src_hwrite (hwrite), .src_htrans (htrans),
    .src_hsize (hsize), .src_hburst (hburst),
    .src_hprot (hprot), .src_hmastlock (hmastlock),
    .src_hwdata (hwdata), .src_hrdata (b_rdata),
    .src_hexcl (hexcl), .src_hmaster (hmaster),
    .src_hexokay (b_exok), .dst_hready (b_dhr),
    .dst_hready_resp (b_srdy), .dst_hresp (b_zero),
    .dst_haddr (b_dad), .dst_hwrite (b_dwr),
    .dst_htrans (b_dtr), .dst_hsize (b_dsz),
    .dst_hburst (b_dbu), .dst_hprot (b_dpr),
    .dst_hmastlock (b_dml), .dst_hwdata (b_dwd),
    .dst_hrdata (b_zrd), .dst_hexcl (b_dex),
    .dst_hmaster (b_dms), .dst_hexokay (b_zero),
    .err_count (b_cnt), .err_count_clr (clr)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] t, input logic [WA-1:0] a);
    @(posedge clk);
    #1;
    htrans = t;
    haddr  = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(HTRANS_IDLE, '0);
  endtask

  task automatic err_xfer();
    cyc(HTRANS_NONSEQ, 32'h8000_0000);
    cyc(HTRANS_IDLE, '0);
    cyc(HTRANS_IDLE, '0);
  endtask

  initial begin
    #12;
    chk("rst_rdy", a_rdy, 1);
    chk("rst_resp", a_resp, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_exok", a_exok, 0);
    chk("rst_trans", a_dtr, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // single read to port 1 with one wait state
    cyc(HTRANS_NONSEQ, 32'h4000_0010);
    s_rdy = 2'b01;
    s_rdata = {32'hDEAD_BEEF, 32'h1111_1111};
    @(negedge clk);
    chk("rd_trans", a_dtr, 4'b1000);
    cyc(HTRANS_IDLE, '0);
    @(negedge clk);
    chk("rd_wait", a_rdy, 0);
    @(posedge clk);
    #1;
    s_rdy = 2'b11;
    s_exok = 2'b10;
    @(negedge clk);
    chk("rd_done", a_rdy, 1);
    chk("rd_data", a_rdata, 32'hDEAD_BEEF);
    chk("rd_exok", a_exok, 1);
    @(posedge clk);
    #1;
    s_exok = 2'b00;
    @(negedge clk);
    chk("rd_idle_data", a_rdata, 0);

    // INCR4 burst: decode held even when a beat looks like port 1
    hburst = 3'b011;
    cyc(HTRANS_NONSEQ, 32'h2000_0FF8);
    @(negedge clk);
    chk("b_beat0", a_dtr, 4'b0010);
    cyc(HTRANS_SEQ, 32'h2000_0FFC);
    @(negedge clk);
    chk("b_beat1", a_dtr, 4'b0011);
    cyc(HTRANS_SEQ, 32'h2000_1000);
    @(negedge clk);
    chk("b_beat2", a_dtr, 4'b0011);
    cyc(HTRANS_SEQ, 32'h4000_1004);
    @(negedge clk);
    chk("b_beat3", a_dtr, 4'b0011);
    chk("b_rdy", a_rdy, 1);
    hburst = 3'b000;
    idle(3);

    // unmapped access: two-cycle ERROR
    cyc(HTRANS_NONSEQ, 32'h8000_0000);
    @(negedge clk);
    chk("um_trans", a_dtr, 0);
    cyc(HTRANS_IDLE, '0);
    @(negedge clk);
    chk("um_rdy1", a_rdy, 0);
    chk("um_resp1", a_resp, 1);
    chk("um_cnt0", a_cnt, 0);
    cyc(HTRANS_IDLE, '0);
    @(negedge clk);
    chk("um_rdy2", a_rdy, 1);
    chk("um_resp2", a_resp, 1);
    chk("um_cnt1", a_cnt, 1);
    cyc(HTRANS_IDLE, '0);
    @(negedge clk);
    chk("um_after", a_resp, 0);
    idle(3);

    // overlap: port 0 wins; on b port 0 is disconnected -> error
    cyc(HTRANS_NONSEQ, 32'h2000_0000);
    @(negedge clk);
    chk("ov_trans_a", a_dtr, 4'b0010);
    chk("ov_trans_b", b_dtr, 0);
    cyc(HTRANS_IDLE, '0);
    @(negedge clk);
    chk("cm_rdy1", b_rdy, 0);
    chk("cm_resp1", b_resp, 1);
    @(posedge clk);
    @(negedge clk);
    chk("cm_rdy2", b_rdy, 1);
    chk("cm_resp2", b_resp, 1);
    idle(3);

    // saturation at 0xFF
    for (int i = 0; i < 254; i++) err_xfer();
    @(negedge clk);
    chk("sat_ff", a_cnt, 8'hFF);
    err_xfer();
    @(negedge clk);
    chk("sat_hold", a_cnt, 8'hFF);

    // clear alone, then clear together with an error
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("clr_only", a_cnt, 0);
    cyc(HTRANS_NONSEQ, 32'h8000_0000);
    cyc(HTRANS_IDLE, '0);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_ph1", a_rdy, 0);
    cyc(HTRANS_IDLE, '0);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_prio", a_cnt, 0);
    idle(2);

    // reset during ERROR cycle 1
    cyc(HTRANS_NONSEQ, 32'h8000_0000);
    cyc(HTRANS_IDLE, '0);
    @(negedge clk);
    chk("rst_ph1", a_rdy, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_rdy", a_rdy, 1);
    chk("rst_mid_resp", a_resp, 0);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_after_rdy", a_rdy, 1);
    chk("rst_after_resp", a_resp, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
